// File: rtl/vector_box_side_solver_pkg.sv
// Purpose : shared defaults, FSM state type and counter width for the box side solver.
// Latency : n/a (type and constant definitions only).
// Backpr. : n/a.
package vbox_pkg;

  localparam int AREA_W_DEF = 8;
  localparam int SIDE_W_DEF = 4;
  localparam int CNT_W_DEF  = $clog2(AREA_W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/vector_box_side_solver_if.sv
// Purpose : request/result bundle of the box side solver (area + known side in, H/R/flags out).
// Latency : n/a (signal bundle only).
// Backpr. : start is ignored while busy or done is high; there is no queueing.
// Ports   : master = requester (drives start, Area_high/low, W, B);
//           slave  = solver (drives busy, done, H, R, exact, err, D_out, d_ovf).
interface vector_box_side_solver_if
  import vbox_pkg::*;
#(
  parameter int AREA_W = AREA_W_DEF,
  parameter int SIDE_W = SIDE_W_DEF
) ();

  logic                  start;
  logic [AREA_W/2-1:0]   Area_high;
  logic [AREA_W/2-1:0]   Area_low;
  logic [SIDE_W-1:0]     W;
  logic [SIDE_W-1:0]     B;
  logic                  busy;
  logic                  done;
  logic [AREA_W-1:0]     H;
  logic [SIDE_W-1:0]     R;
  logic                  exact;
  logic                  err;
  logic [SIDE_W-1:0]     D_out;
  logic                  d_ovf;

  modport master (
    output start, Area_high, Area_low, W, B,
    input  busy, done, H, R, exact, err, D_out, d_ovf
  );

  modport slave (
    input  start, Area_high, Area_low, W, B,
    output busy, done, H, R, exact, err, D_out, d_ovf
  );

endinterface

// File: rtl/vector_box_side_solver_div_step.sv
// Purpose : one combinational restoring-division step (shift in a dividend bit, trial subtract W).
// Latency : combinational.
// Backpr. : none.
// Ports   : rem_in (partial remainder, always < W), q_bit (next dividend bit, MSB first), W (divisor)
//           -> rem_out (new partial remainder), q_out (quotient bit).
module vbox_div_step
  import vbox_pkg::*;
#(
  parameter int SIDE_W = SIDE_W_DEF
) (
  input  logic [SIDE_W-1:0] rem_in,
  input  logic              q_bit,
  input  logic [SIDE_W-1:0] W,
  output logic [SIDE_W-1:0] rem_out,
  output logic              q_out
);

  // One extra bit: rem_in < W, so the shifted value is < 2*W and fits in SIDE_W+1 bits.
  logic [SIDE_W:0] rem_shift;

  always_comb begin
    rem_shift = {rem_in, q_bit};
    q_out     = (rem_shift >= {1'b0, W});
    // After a successful subtract the result is < W, so it fits back in SIDE_W bits.
    rem_out   = q_out ? SIDE_W'(rem_shift - {1'b0, W}) : rem_shift[SIDE_W-1:0];
  end

endmodule

// File: rtl/vector_box_side_solver.sv
// Purpose : H = area / W and R = area % W via an AREA_W-step restoring divider; err on W == 0.
// Latency : done at N+AREA_W+1 after start is sampled at edge N (N+1 for W == 0); busy N+1..N+AREA_W.
// Backpr. : start accepted only in IDLE (busy == 0 and done == 0); otherwise dropped, never queued.
// Ports   : clk, rst (sync, active high), bus (slave modport of vector_box_side_solver_if).
// Option  : VBOX_SOLVE_CORNER_EN adds D_out = B + H (truncated to SIDE_W) and d_ovf on carry-out;
//           without it D_out/d_ovf are tied low and B is ignored.
module vector_box_side_solver
  import vbox_pkg::*;
#(
  parameter int AREA_W = AREA_W_DEF,
  parameter int SIDE_W = SIDE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  vector_box_side_solver_if.slave   bus
);

  localparam int CNT_W = $clog2(AREA_W);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [SIDE_W-1:0]   rem;
  logic [AREA_W-1:0]   q;
  logic [SIDE_W-1:0]   w_q;

  logic                busy_q;
  logic                done_q;
  logic [AREA_W-1:0]   h_q;
  logic [SIDE_W-1:0]   r_q;
  logic                exact_q;
  logic                err_q;
  logic [SIDE_W-1:0]   d_out_q;
  logic                d_ovf_q;

  logic [AREA_W-1:0]   area_in;
  logic [SIDE_W-1:0]   step_rem;
  logic                step_q;
  logic [AREA_W-1:0]   h_next;

  assign area_in = {bus.Area_high, bus.Area_low};

  // The quotient shifts in from the bottom as dividend bits leave from the top,
  // so one register holds both.
  vbox_div_step #(.SIDE_W(SIDE_W)) u_step (
    .rem_in  (rem),
    .q_bit   (q[AREA_W-1]),
    .W       (w_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  assign h_next = {q[AREA_W-2:0], step_q};

`ifdef VBOX_SOLVE_CORNER_EN
  logic [SIDE_W-1:0]   b_q;
  logic [AREA_W:0]     corner_sum;

  assign corner_sum = {1'b0, h_next} + {{(AREA_W+1-SIDE_W){1'b0}}, b_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      q       <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_q     <= '0;
      r_q     <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
      d_out_q <= '0;
      d_ovf_q <= 1'b0;
`ifdef VBOX_SOLVE_CORNER_EN
      b_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.W == '0) begin
              // Divide by zero: publish the error result on the very next cycle.
              state   <= ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              h_q     <= '1;
              r_q     <= '0;
              exact_q <= 1'b0;
              d_out_q <= '0;
`ifdef VBOX_SOLVE_CORNER_EN
              d_ovf_q <= 1'b1;
`else
              d_ovf_q <= 1'b0;
`endif
            end else begin
              // Previous results stay visible; only the sticky err is cleared.
              state  <= DIV;
              busy_q <= 1'b1;
              err_q  <= 1'b0;
              count  <= '0;
              rem    <= '0;
              q      <= area_in;
              w_q    <= bus.W;
`ifdef VBOX_SOLVE_CORNER_EN
              b_q    <= bus.B;
`endif
            end
          end
        end

        DIV: begin
          q     <= h_next;
          rem   <= step_rem;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(AREA_W - 1)) begin
            // Last step: results go straight from the step outputs so they
            // are valid in the same cycle done rises.
            state   <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            h_q     <= h_next;
            r_q     <= step_rem;
            exact_q <= (step_rem == '0);
`ifdef VBOX_SOLVE_CORNER_EN
            d_out_q <= corner_sum[SIDE_W-1:0];
            d_ovf_q <= |corner_sum[AREA_W:SIDE_W];
`endif
          end
        end

        DONE, ERR: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.H     = h_q;
  assign bus.R     = r_q;
  assign bus.exact = exact_q;
  assign bus.err   = err_q;
  assign bus.D_out = d_out_q;
  assign bus.d_ovf = d_ovf_q;

endmodule

// File: tb/tb_vector_box_side_solver.sv
// Purpose : directed scoreboard bench for vector_box_side_solver (results, latency, err, abort, ignored start).
// Latency : expected done cycle is stored per request and compared by the monitor.
// Backpr. : requests are issued only once the previous expected result has been consumed.
module tb_vector_box_side_solver;

  localparam int AREA_W = 8;
  localparam int SIDE_W = 4;

  typedef struct {
    int h;
    int r;
    int exact;
    int err;
    int d_out;
    int d_ovf;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  vector_box_side_solver_if #(.AREA_W(AREA_W), .SIDE_W(SIDE_W)) bus ();

  vector_box_side_solver #(.AREA_W(AREA_W), .SIDE_W(SIDE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc + 1);
    end
  endtask

  // Monitor: cycle k+1 is the cycle following active edge k.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc + 1);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc + 1, e.due);
        chk("H", int'(bus.H), e.h);
        chk("R", int'(bus.R), e.r);
        chk("exact", int'(bus.exact), e.exact);
        chk("err", int'(bus.err), e.err);
        chk("D_out", int'(bus.D_out), e.d_out);
        chk("d_ovf", int'(bus.d_ovf), e.d_ovf);
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  // Drives one request; returns at the negedge right after the accepting edge.
  // Inputs are scrambled afterwards: the DUT must have captured them already.
  task automatic issue(input logic [7:0] area, input logic [3:0] w, input logic [3:0] b,
                       input bit push, input int h, input int r, input int exact,
                       input int err, input int c_dout, input int c_dovf);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.Area_high = area[7:4];
    bus.Area_low  = area[3:0];
    bus.W         = w;
    bus.B         = b;
    bus.start     = 1'b1;
    n = cyc + 1;
    if (push) begin
      e.h     = h;
      e.r     = r;
      e.exact = exact;
      e.err   = err;
`ifdef VBOX_SOLVE_CORNER_EN
      e.d_out = c_dout;
      e.d_ovf = c_dovf;
`else
      e.d_out = 0;
      e.d_ovf = 0;
`endif
      e.due   = (w == 4'd0) ? n + 1 : n + AREA_W + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.Area_high = 4'($urandom);
    bus.Area_low  = 4'($urandom);
    bus.W         = 4'($urandom);
    bus.B         = 4'($urandom);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d results pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int done_seen;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.Area_high = '0;
    bus.Area_low = '0;
    bus.W = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_exact", int'(bus.exact), 0);
    chk("rst_H", int'(bus.H), 0);
    chk("rst_R", int'(bus.R), 0);
    chk("rst_D_out", int'(bus.D_out), 0);
    chk("rst_d_ovf", int'(bus.d_ovf), 0);

    //     area   W      B      push H    R  ex err Dout ovf
    issue(8'h3C, 4'd5,  4'd3,  1,   12,  0, 1, 0,  15,  0); wait_drain("a60_w5");
    issue(8'h64, 4'd7,  4'd3,  1,   14,  2, 0, 0,  1,   1); wait_drain("a100_w7");
    issue(8'hE1, 4'd15, 4'd0,  1,   15,  0, 1, 0,  15,  0); wait_drain("a225_w15");
    issue(8'hFF, 4'd1,  4'd1,  1,   255, 0, 1, 0,  0,   1); wait_drain("a255_w1");
    issue(8'h00, 4'd3,  4'd4,  1,   0,   0, 1, 0,  4,   0); wait_drain("a0_w3");

    // Divide by zero, err must persist until the next accepted start.
    issue(8'h5A, 4'd0,  4'd2,  1,   255, 0, 0, 1,  0,   1); wait_drain("w0");
    repeat (3) @(negedge clk);
    chk("err_hold", int'(bus.err), 1);
    chk("H_hold", int'(bus.H), 255);
    issue(8'h3C, 4'd5,  4'd2,  1,   12,  0, 1, 0,  14,  0);
    chk("err_clear_on_start", int'(bus.err), 0);
    chk("busy_after_start", int'(bus.busy), 1);
    chk("H_unchanged_on_start", int'(bus.H), 255);
    wait_drain("after_err");

    // Second start three edges after acceptance must be dropped.
    issue(8'h64, 4'd7,  4'd3,  1,   14,  2, 0, 0,  1,   1);
    repeat (2) @(negedge clk);
    chk("busy_mid", int'(bus.busy), 1);
    bus.Area_high = 4'h3;
    bus.Area_low  = 4'hC;
    bus.W         = 4'd5;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("ignored_start");
    repeat (12) @(negedge clk);

    // Abort: reset at accept+4, no result may appear afterwards.
    issue(8'h3C, 4'd5,  4'd3,  0,   0,   0, 0, 0,  0,   0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_H", int'(bus.H), 0);
    chk("abort_R", int'(bus.R), 0);
    chk("abort_exact", int'(bus.exact), 0);
    chk("abort_err", int'(bus.err), 0);
    chk("abort_d_ovf", int'(bus.d_ovf), 0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);

    // Recovery after abort.
    issue(8'h64, 4'd10, 4'd5,  1,   10,  0, 1, 0,  15,  0); wait_drain("a100_w10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_box_side_solver.md
Name: vector_box_side_solver

Overview:
- Inverse of the box-area multiplier. Given a box area, supplied as high/low nibbles, and one known side length W, it computes the other side H = area / W and the remainder.
- Multi-cycle restoring divider with a start/busy/done handshake.
- Sits in the Mini SPU vector unit beside the area block. Used for "fit box of given area" queries.

Parameters:
- AREA_W, 8, area width; the Area_high/Area_low nibble split is AREA_W/2 each.
- SIDE_W, 4, width of the known side W and of the corner coordinates.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- Area_high  in  AREA_W/2  upper nibble of the area.
- Area_low  in  AREA_W/2  lower nibble of the area.
- W  in  SIDE_W  known side length (deltaX).
- B  in  SIDE_W  base Y corner; used only with the optional feature.
- busy  out  1  division in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- H  out  AREA_W  quotient (the other side).
- R  out  SIDE_W  remainder.
- exact  out  1  R == 0 and err == 0.
- err  out  1  divide-by-zero (W == 0).
- D_out  out  SIDE_W  derived corner; optional feature only.
- d_ovf  out  1  corner overflow; optional feature only.

Behaviour:
- Reset: state IDLE, count=0. busy, done, err, exact, H, R, D_out and d_ovf are all 0.
- States:
  - IDLE: on start=1, capture area={Area_high,Area_low}, W and B.
    - If W==0, go to ERR.
    - Otherwise go to DIV with count=0, partial remainder 0 (SIDE_W+1 bits) and the quotient shift register loaded with the area.
  - DIV: busy=1. Each cycle performs one restoring step, MSB-first:
    - rem = {rem[SIDE_W-1:0], q_msb}
    - if rem >= W then rem -= W and shift in 1, else shift in 0.
    - After AREA_W steps (count == AREA_W-1), go to DONE.
  - DONE: register H, R and exact. Pulse done=1 for exactly one cycle, busy=0, return to IDLE.
  - ERR: done=1 and err=1 for one cycle. H = all ones, R=0, exact=0. Return to IDLE.
- Latency: start sampled at edge N.
  - busy is high during cycles N+1 .. N+AREA_W.
  - done is high at cycle N+AREA_W+1 (9 cycles for the defaults).
  - The W==0 path raises done at N+1.
- Results hold after done until the next done. Outputs do not change when start is accepted.
- err holds until the next accepted start, which clears it.
- start while busy=1 or while done=1 is ignored; no queueing.
- Inputs are sampled only on the accepting edge. Input changes during DIV have no effect.
- rst asserted mid-operation aborts immediately to the reset values; no done pulse.
- Widths: the intermediate remainder is SIDE_W+1 bits so the compare cannot overflow. H spans the full AREA_W because W=1 yields H=area.

Optional Feature:
- Macro: VBOX_SOLVE_CORNER_EN
- With the macro defined:
  - At DONE, D_out = (B + H) truncated to SIDE_W bits.
  - d_ovf = 1 when B + H > 2^SIDE_W − 1.
  - In ERR, D_out=0 and d_ovf=1.
- Without the macro: D_out and d_ovf are tied to 0 and the B input is unused; no adder is built.

Decomposition:
- Package vbox_pkg holds:
  - the AREA_W and SIDE_W defaults;
  - the state typedef (IDLE, DIV, DONE, ERR);
  - the count-width constant $clog2(AREA_W).
- One natural sub-module: vbox_div_step, a combinational single restoring step taking rem_in, q_bit and W and producing rem_out and q_out. It is instantiated once and iterated by the FSM.

Test Plan:
- Area_high=3, Area_low=C (60), W=5 -> done at start+9: H=12, R=0, exact=1, err=0.
- Area 0x64 (100), W=7 -> H=14, R=2, exact=0.
- Area 0xE1 (225), W=15 -> H=15, R=0. Area 0xFF, W=1 -> H=255, R=0.
- W=0, any area -> done at start+1 with err=1, H=0xFF. A following valid start clears err.
- start pulsed again at start+3 with different inputs -> ignored; the original result is delivered. rst at start+4 -> busy=0, no done, all outputs 0.
- VBOX_SOLVE_CORNER_EN: B=3 with 60/5 -> D_out=15, d_ovf=0. B=3 with 100/7 -> D_out=1, d_ovf=1.
